// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader placed directly upstream of the single-cycle MIPS core.
//   It accepts a framed byte stream and assembles big-endian 32-bit words.
//   Each word is written into instruction memory. The core is held in reset
//   until the whole image has been written and its XOR checksum matches.
//
//   Frame layout: LEN_HI, LEN_LO (word count N), 4*N payload bytes with the
//   MSB of each word first, then CHK. CHK is the XOR of the payload bytes only.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   start         one-cycle pulse; starts a load from IDLE, DONE or ERR
//   byte_valid    byte_data carries a byte this cycle
//   byte_data     stream byte
//   byte_ready    loader takes the byte this cycle (transfer = valid & ready)
//   im_we         IM write strobe, one cycle per word
//   im_addr       IM word address
//   im_wdata      IM write data
//   cpu_rst       reset to the MIPS core, active high
//   busy          a load is in progress
//   done          image loaded and verified
//   err           length or checksum error
//   words_loaded  words written in the current or last load
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_RELEASE, S_DONE, S_ERR
  } state_t;

  // Largest legal word count: the whole IM.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         word_q, word_d;     // first three bytes of the current word
  logic [1:0]          bcnt_q, bcnt_d;     // byte position within the word
  logic [ADDR_W:0]     wcnt_q, wcnt_d;     // words fully received
  logic [7:0]          xor_q, xor_d;
  logic [7:0]          hold_q, hold_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     wl_q, wl_d;

  logic                xfer;
  logic [15:0]         len_in;
  logic [ADDR_W:0]     wcnt_inc;

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign xfer       = byte_valid && byte_ready;
  assign len_in     = {len_hi_q, byte_data};
  assign wcnt_inc   = wcnt_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_d     = word_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    xor_d      = xor_q;
    hold_d     = hold_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    wl_d       = wl_q;

    // A write retires one cycle after its fourth byte; bytes keep flowing
    // meanwhile, and the next write cannot arrive sooner than 4 cycles later.
    if (im_we_q) begin
      im_addr_d = im_addr_q + ADDR_W'(1);
      wl_d      = wl_q + (ADDR_W+1)'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN_HI;
          done_d    = 1'b0;
          err_d     = 1'b0;
          wl_d      = '0;
          xor_d     = '0;
          bcnt_d    = '0;
          wcnt_d    = '0;
          cpu_rst_d = 1'b1;
          im_addr_d = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = byte_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_in;
          if ({1'b0, len_in} > CAP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_in == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          xor_d  = xor_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_wdata_d = {word_q, byte_data};
            wcnt_d     = wcnt_inc;
            if (16'(wcnt_inc) == len_q) state_d = S_CHK;
          end else begin
            word_d = {word_q[15:0], byte_data};
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (byte_data == xor_q) begin
            state_d = S_RELEASE;
            hold_d  = 8'(HOLD_CYCLES);
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        // Counting down to zero and then one more cycle puts the release
        // HOLD_CYCLES+1 cycles after the checksum byte.
        if (hold_q == 8'd0) begin
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_q     <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      xor_q      <= '0;
      hold_q     <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wl_q       <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_q     <= word_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      xor_q      <= xor_d;
      hold_q     <= hold_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]       words[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  // Record every IM write seen mid-cycle.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte after a random idle gap; returns at the negedge after
  // the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int tries;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    byte_valid = 1'b0;
    repeat (g) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    while (byte_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (byte_ready !== 1'b1) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start      = 1'b1;
    byte_valid = 1'b1;     // must be ignored: not accepted in this cycle
    byte_data  = 8'hFF;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Load words[0..n-1] as one frame and check the outcome against the model.
  task automatic load_frame(input int n, input bit bad, input int gap,
                            input bit mid_start, input string tag);
    logic [15:0] n16;
    logic [7:0]  x;
    logic [7:0]  c;
    logic [7:0]  b;
    int          k;
    n16 = n[15:0];
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check({tag, "_st_cpu_rst"}, {63'd0, cpu_rst}, 64'd1);
    check({tag, "_st_ready"}, {63'd0, byte_ready}, 64'd1);
    check({tag, "_st_done"}, {63'd0, done}, 64'd0);
    check({tag, "_st_err"}, {63'd0, err}, 64'd0);
    check({tag, "_st_wl"}, 64'(words_loaded), 64'd0);
    check({tag, "_st_addr"}, 64'(im_addr), 64'd0);
    send_byte(n16[15:8], gap);
    send_byte(n16[7:0], gap);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(words[i] >> (8 * (3 - j)));
        x ^= b;
        send_byte(b, gap);
        if (mid_start && i == 0 && j == 1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    c = bad ? (x ^ 8'h06) : x;
    send_byte(c, gap);
    if (!bad) begin
      k = 0;
      while (cpu_rst === 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_release_cycles"}, 64'(k), 64'(HOLD + 1));
      check({tag, "_done"}, {63'd0, done}, 64'd1);
      check({tag, "_err"}, {63'd0, err}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_words_loaded"}, 64'(words_loaded), 64'(n));
    end else begin
      check({tag, "_err"}, {63'd0, err}, 64'd1);
      repeat (HOLD + 3) @(negedge clk);
      check({tag, "_err_hold"}, {63'd0, err}, 64'd1);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_cpu_rst"}, {63'd0, cpu_rst}, 64'd1);
    end
    check({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_waddr"}, 64'(wr_addr[i]), 64'(i));
      check({tag, "_wdata"}, 64'(wr_data[i]), 64'(words[i]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_we"}, {63'd0, im_we}, 64'd0);
    check({tag, "_addr"}, 64'(im_addr), 64'd0);
    check({tag, "_wdata"}, 64'(im_wdata), 64'd0);
    check({tag, "_cpu_rst"}, {63'd0, cpu_rst}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
    check({tag, "_wl"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {63'd0, byte_ready}, 64'd0);
    check("idle_cpu_rst", {63'd0, cpu_rst}, 64'd1);

    // Two-instruction image, correct checksum.
    words = '{32'h20080005, 32'h2009000A};
    load_frame(2, 1'b0, 0, 1'b0, "basic");

    // Same image, wrong checksum byte.
    load_frame(2, 1'b1, 0, 1'b0, "badchk");

    // Empty image.
    words.delete();
    load_frame(0, 1'b0, 0, 1'b0, "empty");

    // Word count one past capacity.
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("toolong_err", {63'd0, err}, 64'd1);
    check("toolong_ready", {63'd0, byte_ready}, 64'd0);
    check("toolong_done", {63'd0, done}, 64'd0);
    check("toolong_cpu_rst", {63'd0, cpu_rst}, 64'd1);

    // Random image, gapless and then with gaps plus a stray start pulse.
    words.delete();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      words.push_back(w);
    end
    load_frame(5, 1'b0, 0, 1'b0, "rand_nogap");
    load_frame(5, 1'b0, 3, 1'b1, "rand_gap");

    // Asynchronous reset after five payload bytes.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int j = 0; j < 5; j++) send_byte(8'hA0 + 8'(j), 0);
    #2 rst = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    words.delete();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      words.push_back(w);
    end
    load_frame(3, 1'b0, 1, 1'b0, "after_rst");

    // Reload straight from DONE with a fresh image.
    words.delete();
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      words.push_back(w);
    end
    load_frame(4, 1'b0, 2, 1'b0, "reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
